// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage controller
// and a variable-latency data memory.
interface mem_access_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: turns M-stage loads/stores
// into req/ack transactions, stalls the pipe, flags misalign/timeout.
module mem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_m,
    input  logic              store_m,
    input  logic [DATA_W-1:0] addr_m,
    input  logic [DATA_W-1:0] wdata_m,
    input  logic [3:0]        waddr_m,
    mem_access_ctrl_if.master bus,
    output logic              stall_m,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [3:0]        rd_waddr,
    output logic              err_align,
    output logic              err_timeout
);
    localparam int CntW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [CntW-1:0]   cnt;
    logic              cntLast;
    logic              op;
    logic              aligned;
    logic              memReq;
    logic              memWe;
    logic [DATA_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [3:0]        waddrLat;
    logic              rdValid;
    logic [DATA_W-1:0] rdData;
    logic [3:0]        rdWaddr;
    logic              errAlign;
    logic              errTimeout;

    assign op      = load_m | store_m;
    assign aligned = (addr_m[1:0] == 2'b00);
    assign cntLast = (cnt == CntW'(TIMEOUT - 1));

    // Pipeline freezes while an op waits in IDLE or an access is in flight
    assign stall_m = ((state == IDLE) && op) || (state == ACCESS);

    assign bus.mem_req   = memReq;
    assign bus.mem_we    = memWe;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;

    assign rd_valid    = rdValid;
    assign rd_data     = rdData;
    assign rd_waddr    = rdWaddr;
    assign err_align   = errAlign;
    assign err_timeout = errTimeout;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: misaligned ops skip the memory and go straight to DONE
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (op) begin
                    stateNext = aligned ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                if (bus.mem_ack || cntLast) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Request, timeout counter and write-back registers; pulses last one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            memReq     <= 1'b0;
            memWe      <= 1'b0;
            memAddr    <= '0;
            memWdata   <= '0;
            waddrLat   <= '0;
            rdValid    <= 1'b0;
            rdData     <= '0;
            rdWaddr    <= '0;
            errAlign   <= 1'b0;
            errTimeout <= 1'b0;
        end else begin
            rdValid    <= 1'b0;
            errAlign   <= 1'b0;
            errTimeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (op && aligned) begin
                        memReq   <= 1'b1;
                        memWe    <= store_m;
                        memAddr  <= {addr_m[DATA_W-1:2], 2'b00};
                        memWdata <= wdata_m;
                        waddrLat <= waddr_m;
                        cnt      <= '0;
                    end else if (op) begin
                        errAlign <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (bus.mem_ack) begin
                        memReq <= 1'b0;
                        if (!memWe) begin
                            rdData  <= bus.mem_rdata;
                            rdWaddr <= waddrLat;
                            rdValid <= 1'b1;
                        end
                    end else if (cntLast) begin
                        memReq     <= 1'b0;
                        errTimeout <= 1'b1;
                        rdData     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
